imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: assembles 4 bytes per word and
// writes word_count words across two 512-word banks, then pulses done.
module imem_loader #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        we0,
    output logic        we1,
    output logic [8:0]  waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE} state_t;

    state_t      state, state_nxt;
    logic [9:0]  widx;
    logic [9:0]  last_idx;
    logic [1:0]  bcnt;
    logic [31:0] asm_word;
    logic [31:0] asm_nxt;
    logic        legal;
    logic        accept;
    logic        last;

    assign legal  = (word_count != 11'd0) && (word_count <= 11'd1024);
    assign accept = in_valid && (state == RECV);
    assign last   = (widx == last_idx);

    // Shift-in keeps partial words intact across in_valid gaps.
    always_comb begin
        asm_nxt = asm_word;
        if (BIG_ENDIAN)
            asm_nxt = {asm_word[23:0], in_byte};
        else
            asm_nxt = {in_byte, asm_word[31:8]};
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && legal) state_nxt = RECV;
            RECV:    if (accept && bcnt == 2'd3) state_nxt = WRITE;
            WRITE:   state_nxt = last ? IDLE : RECV;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RECV);
        busy     = (state != IDLE);
        we0      = (state == WRITE) && !widx[9];
        we1      = (state == WRITE) && widx[9];
        done     = (state == WRITE) && last;
    end

    // word_count of 1024 wraps to 0 in 10 bits, so last_idx = 1023 as required.
    always_ff @(posedge clk) begin
        if (reset) begin
            widx     <= '0;
            last_idx <= '0;
            bcnt     <= '0;
            asm_word <= '0;
            waddr    <= '0;
            wdata    <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            widx     <= '0;
                            bcnt     <= '0;
                            asm_word <= '0;
                            last_idx <= word_count[9:0] - 10'd1;
                            err      <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        bcnt     <= bcnt + 2'd1;
                        asm_word <= asm_nxt;
                        if (bcnt == 2'd3) begin
                            waddr <= widx[8:0];
                            wdata <= asm_nxt;
                        end
                    end
                end
                WRITE: widx <= widx + 10'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: big- and little-endian loaders share stimulus; a
// scoreboard of expected writes is compared at every strobe.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [10:0] word_count;
    logic [7:0]  in_byte;
    logic        in_ready, we0, we1, busy, done, err;
    logic [8:0]  waddr;
    logic [31:0] wdata;
    logic        in_ready_le, we0_le, we1_le, busy_le, done_le, err_le;
    logic [8:0]  waddr_le;
    logic [31:0] wdata_le;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    typedef struct {
        logic        bank;
        logic [8:0]  addr;
        logic [31:0] be;
        logic [31:0] le;
        logic        done;
    } exp_t;
    exp_t q[$];

    typedef struct {
        int          wc;
        logic [31:0] w0;
        bit          gaps;
        bit          spam;
    } vec_t;
    vec_t tbl[6];

    imem_loader #(.BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .we0(we0), .we1(we1), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err));

    imem_loader #(.BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready_le),
        .we0(we0_le), .we1(we1_le), .waddr(waddr_le), .wdata(wdata_le),
        .busy(busy_le), .done(done_le), .err(err_le));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (we0 && we1) chk("both_banks", 1, 0);
        if ({we0_le, we1_le} !== {we0, we1}) chk("le_strobe", {we0_le, we1_le}, {we0, we1});
        if (we0 || we1) begin
            strobes++;
            if (q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bank", we1, e.bank);
                chk("waddr", waddr, e.addr);
                chk("wdata_be", wdata, e.be);
                chk("wdata_le", wdata_le, e.le);
                chk("done", done, e.done);
            end
        end else if (done) begin
            chk("done_without_strobe", 1, 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit spam);
        bit acc;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                in_valid   = 1'b0;
                start      = spam ? 1'($urandom_range(0, 1)) : 1'b0;
                word_count = 11'($urandom_range(0, 1100));
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_byte  = b;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic do_load(input int wc, input logic [31:0] w0, input bit gaps, input bit spam);
        int s0;
        s0 = strobes;
        start = 1'b1;
        word_count = 11'(wc);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_cleared", err, 0);
        chk("busy_after_start", busy, 1);
        @(posedge clk); #1;
        for (int i = 0; i < wc; i++) begin
            logic [31:0] w;
            w = w0 + 32'(i) * 32'h01010101;
            for (int j = 0; j < 4; j++) begin
                if (j == 3) begin
                    exp_t e;
                    e.bank = (i >= 512);
                    e.addr = 9'(i % 512);
                    e.be   = w;
                    e.le   = {w[7:0], w[15:8], w[23:16], w[31:24]};
                    e.done = (i == wc - 1);
                    q.push_back(e);
                end
                send_byte(w[31 - 8*j -: 8], gaps, spam);
            end
        end
        for (int t = 0; t < 10 && busy; t++) @(negedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("queue_drained", q.size(), 0);
        chk("strobe_count", strobes - s0, wc);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_we"}, {we0, we1}, 0);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1,    32'h12345678, 1'b0, 1'b0};
        tbl[1] = '{2,    32'hA0B0C0D0, 1'b0, 1'b0};
        tbl[2] = '{513,  32'h00000000, 1'b0, 1'b0};
        tbl[3] = '{5,    32'h11223344, 1'b1, 1'b1};
        tbl[4] = '{12,   32'h0F1E2D3C, 1'b1, 1'b1};
        tbl[5] = '{1024, 32'hDEADBEEF, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = '0; word_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int v = 0; v < 6; v++)
            do_load(tbl[v].wc, tbl[v].w0, tbl[v].gaps, tbl[v].spam);

        // Illegal counts set err and stay idle; a later legal start clears err.
        start = 1'b1; word_count = 11'd0;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("err_wc0", err, 1);
        chk("busy_wc0", busy, 0);
        @(posedge clk); #1;
        start = 1'b1; word_count = 11'd1025;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_wc1025", err, 1);
        chk("busy_wc1025", busy, 0);
        @(posedge clk); #1;
        do_load(2, 32'h5A6B7C8D, 1'b0, 1'b0);

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; word_count = 11'd1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_prio_busy", busy, 0);
        @(posedge clk); #1;

        // Reset mid-word discards the partial word with no strobe.
        start = 1'b1; word_count = 11'd3;
        @(posedge clk); #1; start = 1'b0;
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        reset = 1'b1; in_valid = 1'b1; in_byte = 8'h03;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_reset_vals("midload");
        repeat (6) @(posedge clk);
        #1;
        chk("midload_no_strobe_q", q.size(), 0);
        do_load(1, 32'hAABBCCDD, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
